stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: two debounced pushbuttons driving an IDLE/RUN/PAUSE
// stopwatch FSM. Produces a TICK count-enable every TICK_DIV cycles
// while running and a one-cycle CLR pulse for the downstream counter.

// Per-key synchronizer + debouncer; press is a one-cycle 1->0 event on
// the accepted level, valid on the same edge that updates that level.
module stopwatch_ctrl_deb #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic key,
    output logic press
);
    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync;
    logic          acc;
    logic [CW-1:0] cnt;
    logic          lvl;
    logic          differ;

    assign lvl    = sync[1];
    assign differ = (lvl != acc);
    // Combinational so the FSM reacts on the very edge acc flips low.
    assign press  = differ && (cnt == CNT_LAST) && !lvl;

    // Two-flop synchronizer, then count consecutive cycles of disagreement.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync <= 2'b11;
            acc  <= 1'b1;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], key};
            if (differ) begin
                if (cnt == CNT_LAST) begin
                    acc <= lvl;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module stopwatch_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KEY_SS,
    input  logic       KEY_CLR,
    output logic       TICK,
    output logic       CLR,
    output logic [1:0] STATE,
    output logic       RUNNING
);
    localparam int NUM_KEYS = 2;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    // Key index 0 = start/stop, 1 = clear.
    logic [NUM_KEYS-1:0] keys;
    logic [NUM_KEYS-1:0] press;
    logic                ss_ev;
    logic                clr_ev;

    state_t        state;
    logic [PW-1:0] presc;
    logic          clr_q;

    assign keys   = {KEY_CLR, KEY_SS};
    assign ss_ev  = press[0];
    assign clr_ev = press[1];

    generate
        for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
            stopwatch_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .CLK   (CLK),
                .RST   (RST),
                .key   (keys[k]),
                .press (press[k])
            );
        end
    endgenerate

    assign TICK    = (state == RUN) && (presc == PRE_LAST);
    assign STATE   = state;
    assign RUNNING = (state == RUN);
    assign CLR     = clr_q;

    // Stopwatch FSM with prescaler; clear wins over start/stop except in RUN,
    // where clear is ignored. The prescaler keeps counting on the edge that
    // leaves RUN, so a pause on a TICK cycle still wraps it to 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            presc <= '0;
            clr_q <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            case (state)
                IDLE: begin
                    presc <= '0;
                    if (clr_ev)     clr_q <= 1'b1;
                    else if (ss_ev) state <= RUN;
                end
                RUN: begin
                    presc <= TICK ? '0 : presc + PW'(1);
                    if (ss_ev) state <= PAUSE;
                end
                PAUSE: begin
                    if (clr_ev) begin
                        state <= IDLE;
                        presc <= '0;
                        clr_q <= 1'b1;
                    end else if (ss_ev) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                    presc <= '0;
                end
            endcase
        end
    end
endmodule
